// File: rtl/timer_sched_ctrl_if.sv
// Config/control bus of the prescaled timer controller.
// The master drives config and control; the slave returns status.
interface timer_sched_ctrl_if #(
    parameter int N  = 16,
    parameter int PW = 8
);
    logic          cfg_we;
    logic [N-1:0]  cfg_period;
    logic [PW-1:0] cfg_prescale;
    logic          cfg_mode;
    logic          start;
    logic          stop;
    logic          irq_ack;
    logic          busy;
    logic          tc;
    logic [N-1:0]  count;
    logic          irq;
    logic          ovf;
    logic          cfg_err;

    modport master (
        output cfg_we, cfg_period, cfg_prescale, cfg_mode,
        output start, stop, irq_ack,
        input  busy, tc, count, irq, ovf, cfg_err
    );

    modport slave (
        input  cfg_we, cfg_period, cfg_prescale, cfg_mode,
        input  start, stop, irq_ack,
        output busy, tc, count, irq, ovf, cfg_err
    );
endinterface

// File: rtl/timer_sched_ctrl.sv
// Prescaled up-counter timer, one-shot or periodic,
// with sticky irq/ovf and a one-cycle registered tc pulse.
module timer_sched_ctrl #(
    parameter int N  = 16,
    parameter int PW = 8
) (
    input logic               clk,
    input logic               reset,
    timer_sched_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_count;
    logic [PW-1:0] r_presc;
    logic [N-1:0]  r_period;
    logic [PW-1:0] r_prescale;
    logic          r_mode;
    logic          r_busy;
    logic          r_tc;
    logic          r_irq;
    logic          r_ovf;
    logic          r_cfg_err;

    logic w_tick;
    logic w_at_end;

    // Prescaler wrap and counter terminal compare (unsigned).
    always_comb begin
        w_tick   = (r_presc == r_prescale);
        w_at_end = (r_count == r_period);
    end

    // Control FSM with datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_period   <= '0;
            r_prescale <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_tc       <= 1'b0;
            r_irq      <= 1'b0;
            r_ovf      <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_tc      <= 1'b0;
            r_cfg_err <= 1'b0;
            // Ack first; a coincident terminal event below overrides irq.
            if (bus.irq_ack) begin
                r_irq <= 1'b0;
                r_ovf <= 1'b0;
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.cfg_we) begin
                        r_period   <= bus.cfg_period;
                        r_prescale <= bus.cfg_prescale;
                        r_mode     <= bus.cfg_mode;
                    end
                    if (bus.start && !bus.stop) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_presc <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.cfg_we) begin
                        r_cfg_err <= 1'b1;
                    end
                    if (bus.stop) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_presc <= '0;
                    end else if (w_tick) begin
                        r_presc <= '0;
                        if (w_at_end) begin
                            r_tc  <= 1'b1;
                            r_irq <= 1'b1;
                            if (r_irq && !bus.irq_ack) begin
                                r_ovf <= 1'b1;
                            end
                            if (r_mode) begin
                                r_count <= '0;
                            end else begin
                                r_state <= S_DONE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.tc      = r_tc;
    assign bus.count   = r_count;
    assign bus.irq     = r_irq;
    assign bus.ovf     = r_ovf;
    assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_timer_sched_ctrl.sv
// Directed bench for timer_sched_ctrl.
// Inputs change 1 time unit after each rising edge; outputs sampled there too.
module tb_timer_sched_ctrl;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    timer_sched_ctrl_if #(.N(16), .PW(8)) bus ();

    timer_sched_ctrl #(.N(16), .PW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [15:0] p, input logic [7:0] ps,
                       input logic m);
        bus.cfg_we       = 1'b1;
        bus.cfg_period   = p;
        bus.cfg_prescale = ps;
        bus.cfg_mode     = m;
    endtask

    task automatic idle_in();
        bus.cfg_we  = 1'b0;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.cfg_period   = '0;
        bus.cfg_prescale = '0;
        bus.cfg_mode     = 1'b0;
        idle_in();
        step(2);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tc", bus.tc, 0);
        chk("rst_cnt", bus.count, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_err", bus.cfg_err, 0);
        reset = 1'b0;
        step(1);

        // Periodic, period 3, prescale 0; config and start together.
        cfg(16'd3, 8'd0, 1'b1);
        bus.start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step(1);
            idle_in();
            chk("p_tc", bus.tc, (k == 5 || k == 9 || k == 13));
            chk("p_cnt", bus.count, (k - 1) % 4);
            chk("p_busy", bus.busy, 1);
            if (k == 4) chk("p_irq0", bus.irq, 0);
            if (k == 5) chk("p_irq1", bus.irq, 1);
            if (k == 5) chk("p_ovf0", bus.ovf, 0);
            if (k == 9) chk("p_ovf1", bus.ovf, 1);
        end
        // Stop on the cycle whose closing edge is terminal.
        step(3);
        chk("sp_pre_cnt", bus.count, 3);
        bus.stop = 1'b1;
        step(1);
        idle_in();
        chk("sp_busy", bus.busy, 0);
        chk("sp_tc", bus.tc, 0);
        chk("sp_cnt", bus.count, 3);
        chk("sp_irq", bus.irq, 1);
        chk("sp_ovf", bus.ovf, 1);
        step(3);
        chk("sp_tc2", bus.tc, 0);
        chk("sp_cnt2", bus.count, 3);
        // Ack clears both sticky flags.
        bus.irq_ack = 1'b1;
        step(1);
        idle_in();
        chk("ack_irq", bus.irq, 0);
        chk("ack_ovf", bus.ovf, 0);

        // One-shot, period 2, prescale 1: tc at c+7 only.
        cfg(16'd2, 8'd1, 1'b0);
        step(1);
        idle_in();
        bus.start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            step(1);
            idle_in();
            chk("os_tc", bus.tc, (k == 7));
            chk("os_busy", bus.busy, (k < 7));
            chk("os_cnt", bus.count, (k >= 7) ? 2 : (k - 1) / 2);
            if (k == 7) chk("os_irq", bus.irq, 1);
        end

        // Overrun, set-wins ack, then stop+start together.
        bus.irq_ack = 1'b1;
        step(1);
        idle_in();
        chk("ov_clr", bus.irq, 0);
        cfg(16'd1, 8'd0, 1'b1);
        bus.start = 1'b1;
        step(1);
        idle_in();
        step(2);
        chk("ov_tc1", bus.tc, 1);
        chk("ov_irq1", bus.irq, 1);
        chk("ov_ovf1", bus.ovf, 0);
        step(2);
        chk("ov_tc2", bus.tc, 1);
        chk("ov_ovf2", bus.ovf, 1);
        step(1);
        bus.irq_ack = 1'b1;
        step(1);
        chk("sw_tc", bus.tc, 1);
        chk("sw_irq", bus.irq, 1);
        chk("sw_ovf", bus.ovf, 0);
        step(1);
        idle_in();
        chk("ak_irq", bus.irq, 0);
        chk("ak_ovf", bus.ovf, 0);
        chk("ak_cnt", bus.count, 1);
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        step(1);
        idle_in();
        chk("ss_busy", bus.busy, 0);
        chk("ss_tc", bus.tc, 0);
        chk("ss_cnt", bus.count, 1);
        chk("ss_irq", bus.irq, 0);
        step(2);
        chk("ss_busy2", bus.busy, 0);
        chk("ss_cnt2", bus.count, 1);

        // Config lockout during RUN, then accepted after stop.
        cfg(16'd3, 8'd0, 1'b1);
        bus.start = 1'b1;
        step(1);
        idle_in();
        cfg(16'd9, 8'd0, 1'b0);
        step(1);
        idle_in();
        chk("lk_err1", bus.cfg_err, 1);
        step(1);
        chk("lk_err0", bus.cfg_err, 0);
        step(1);
        chk("lk_tc0", bus.tc, 0);
        step(1);
        chk("lk_tc1", bus.tc, 1);
        chk("lk_busy", bus.busy, 1);
        bus.stop = 1'b1;
        step(1);
        idle_in();
        chk("lk_stop", bus.busy, 0);
        cfg(16'd9, 8'd0, 1'b0);
        bus.start = 1'b1;
        step(1);
        idle_in();
        chk("lk_err_ok", bus.cfg_err, 0);
        step(9);
        chk("lk9_tc0", bus.tc, 0);
        chk("lk9_cnt", bus.count, 9);
        step(1);
        chk("lk9_tc1", bus.tc, 1);
        chk("lk9_busy", bus.busy, 0);
        chk("lk9_cnt2", bus.count, 9);

        // Mid-run reset with irq pending.
        cfg(16'd5, 8'd0, 1'b1);
        bus.start = 1'b1;
        step(1);
        idle_in();
        step(2);
        chk("mr_cnt", bus.count, 2);
        chk("mr_irq", bus.irq, 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("mr_busy", bus.busy, 0);
        chk("mr_cnt0", bus.count, 0);
        chk("mr_irq0", bus.irq, 0);
        chk("mr_ovf0", bus.ovf, 0);
        chk("mr_tc0", bus.tc, 0);
        // Config was cleared: period 0, one-shot, tc two cycles after start.
        bus.start = 1'b1;
        step(1);
        idle_in();
        chk("pr_busy", bus.busy, 1);
        step(1);
        chk("pr_tc", bus.tc, 1);
        chk("pr_busy0", bus.busy, 0);
        chk("pr_irq", bus.irq, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
